// File: rtl/num_glyph_pixel.sv
// num_glyph_pixel
// ---------------------------------------------------------------------------
// Purpose:
//    Overlays one cell glyph on the VGA pixel stream. The glyph can be a digit
//    1-8, a mine or a flag. Glyphs come from an internal 8x16 bitmap ROM. Each
//    bitmap is magnified by 2**SCALE_LOG2 and drawn in a colour chosen by its
//    code. The pipeline has three register stages:
//       stage 1 : window test, glyph column/row, sample of the per-pixel inputs
//       stage 2 : registered ROM read of one bitmap line
//       stage 3 : bit select, blanking and compositing into rgb_out
//    The VGA timing signals go through a plain 3-deep delay line, so they stay
//    aligned with rgb_out.
//
// Ports:
//    clk, rst                  pixel clock, asynchronous active-high reset
//    hcount_in/vcount_in       11-bit pixel counters
//    hsync_in/vsync_in         sync strobes
//    hblnk_in/vblnk_in         blanking strobes
//    rgb_in                    upstream 12-bit pixel colour
//    tile_x/tile_y             top-left corner of the glyph, per pixel
//    glyph_code                0 blank, 1-8 digit, 9 mine, 10 flag, else blank
//    glyph_en                  0 forces passthrough for this pixel
//    *_out                     timing delayed by 3 cycles
//    rgb_out                   composited pixel
//    glyph_hit                 1 when rgb_out carries glyph foreground
// ---------------------------------------------------------------------------
module num_glyph_pixel #(
   parameter int          SCALE_LOG2 = 1,
   parameter logic [11:0] BG_BLANK   = 12'h000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] hcount_in,
   input  logic        hsync_in,
   input  logic        hblnk_in,
   input  logic [10:0] vcount_in,
   input  logic        vsync_in,
   input  logic        vblnk_in,
   input  logic [11:0] rgb_in,
   input  logic [10:0] tile_x,
   input  logic [10:0] tile_y,
   input  logic [3:0]  glyph_code,
   input  logic        glyph_en,
   output logic [10:0] hcount_out,
   output logic        hsync_out,
   output logic        hblnk_out,
   output logic [10:0] vcount_out,
   output logic        vsync_out,
   output logic        vblnk_out,
   output logic [11:0] rgb_out,
   output logic        glyph_hit
);

   // On-screen footprint of one glyph after magnification.
   localparam logic [11:0] GLYPH_W = 12'd8 << SCALE_LOG2;
   localparam logic [11:0] GLYPH_H = 12'd16 << SCALE_LOG2;

   // Bitmap ROM contents. Only rows 2..11 of each glyph can be non-zero, so
   // every glyph is stored as ten packed bytes with row 2 in the top byte.
   // Codes outside 1..10 read as all zeros.
   function automatic logic [7:0] romLine(input logic [7:0] addr);
      logic [79:0] rows;
      int          sel;
      rows = '0;
      case (addr[7:4])
         4'd1:    rows = 80'h18_38_78_18_18_18_18_18_18_7E;
         4'd2:    rows = 80'h7C_C6_06_0C_18_30_60_C0_C6_FE;
         4'd3:    rows = 80'h7C_C6_06_06_3C_06_06_06_C6_7C;
         4'd4:    rows = 80'h0C_1C_3C_6C_CC_FE_0C_0C_0C_1E;
         4'd5:    rows = 80'hFE_C0_C0_C0_FC_06_06_06_C6_7C;
         4'd6:    rows = 80'h38_60_C0_C0_FC_C6_C6_C6_C6_7C;
         4'd7:    rows = 80'hFE_C6_06_06_0C_18_30_30_30_30;
         4'd8:    rows = 80'h7C_C6_C6_C6_7C_C6_C6_C6_C6_7C;
         4'd9:    rows = 80'h10_54_38_FE_38_54_10_00_00_00;
         4'd10:   rows = 80'h30_38_3C_38_30_30_30_30_FC_FC;
         default: rows = '0;
      endcase
      if ((addr[3:0] >= 4'd2) && (addr[3:0] <= 4'd11)) begin
         sel     = 8 * (11 - int'(addr[3:0]));
         romLine = rows[sel +: 8];
      end else begin
         romLine = 8'h00;
      end
   endfunction

   // Foreground colour for each glyph code.
   function automatic logic [11:0] fgColour(input logic [3:0] code);
      case (code)
         4'd1:    fgColour = 12'h00F;
         4'd2:    fgColour = 12'h080;
         4'd3:    fgColour = 12'hF00;
         4'd4:    fgColour = 12'h008;
         4'd5:    fgColour = 12'h800;
         4'd6:    fgColour = 12'h088;
         4'd7:    fgColour = 12'h000;
         4'd8:    fgColour = 12'h888;
         4'd9:    fgColour = 12'h000;
         4'd10:   fgColour = 12'hF00;
         default: fgColour = 12'h000;
      endcase
   endfunction

   // Stage 1 combinational window test. The window ends are summed in 12 bits,
   // so a tile near the right or bottom edge cannot wrap its end back past zero.
   // The counters are compared before any subtraction. Because of that, the
   // wrapped difference only matters for pixels inside the window.
   logic [11:0] w_xEnd;
   logic [11:0] w_yEnd;
   logic        w_inX;
   logic        w_inY;
   logic        w_codeOk;
   logic [10:0] w_dx;
   logic [10:0] w_dy;
   logic [2:0]  w_col;
   logic [3:0]  w_row;

   assign w_xEnd   = {1'b0, tile_x} + GLYPH_W;
   assign w_yEnd   = {1'b0, tile_y} + GLYPH_H;
   assign w_inX    = ({1'b0, hcount_in} >= {1'b0, tile_x}) && ({1'b0, hcount_in} < w_xEnd);
   assign w_inY    = ({1'b0, vcount_in} >= {1'b0, tile_y}) && ({1'b0, vcount_in} < w_yEnd);
   assign w_codeOk = (glyph_code >= 4'd1) && (glyph_code <= 4'd10);
   assign w_dx     = hcount_in - tile_x;
   assign w_dy     = vcount_in - tile_y;
   assign w_col    = 3'(w_dx >> SCALE_LOG2);
   assign w_row    = 4'(w_dy >> SCALE_LOG2);

   // Stage 1 registers. Each pixel keeps its own glyph position and code. The
   // valid flag combines the window test, the enable and the code range. The
   // later stages therefore never need the raw tile inputs.
   logic [2:0]  r1Col;
   logic [3:0]  r1Row;
   logic [3:0]  r1Code;
   logic        r1Valid;
   logic [11:0] r1Rgb;
   logic [10:0] r1Hcount;
   logic [10:0] r1Vcount;
   logic        r1Hsync;
   logic        r1Hblnk;
   logic        r1Vsync;
   logic        r1Vblnk;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r1Col    <= '0;
         r1Row    <= '0;
         r1Code   <= '0;
         r1Valid  <= 1'b0;
         r1Rgb    <= '0;
         r1Hcount <= '0;
         r1Vcount <= '0;
         r1Hsync  <= 1'b0;
         r1Hblnk  <= 1'b0;
         r1Vsync  <= 1'b0;
         r1Vblnk  <= 1'b0;
      end else begin
         r1Col    <= w_col;
         r1Row    <= w_row;
         r1Code   <= glyph_code;
         r1Valid  <= w_inX && w_inY && glyph_en && w_codeOk;
         r1Rgb    <= rgb_in;
         r1Hcount <= hcount_in;
         r1Vcount <= vcount_in;
         r1Hsync  <= hsync_in;
         r1Hblnk  <= hblnk_in;
         r1Vsync  <= vsync_in;
         r1Vblnk  <= vblnk_in;
      end
   end

   // Stage 2 performs the synchronous ROM read at address {code, row}. The
   // column, code and timing are carried alongside the line so that they stay
   // aligned with the bitmap line they belong to.
   logic [7:0]  r2Line;
   logic [2:0]  r2Col;
   logic [3:0]  r2Code;
   logic        r2Valid;
   logic [11:0] r2Rgb;
   logic [10:0] r2Hcount;
   logic [10:0] r2Vcount;
   logic        r2Hsync;
   logic        r2Hblnk;
   logic        r2Vsync;
   logic        r2Vblnk;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r2Line   <= '0;
         r2Col    <= '0;
         r2Code   <= '0;
         r2Valid  <= 1'b0;
         r2Rgb    <= '0;
         r2Hcount <= '0;
         r2Vcount <= '0;
         r2Hsync  <= 1'b0;
         r2Hblnk  <= 1'b0;
         r2Vsync  <= 1'b0;
         r2Vblnk  <= 1'b0;
      end else begin
         r2Line   <= romLine({r1Code, r1Row});
         r2Col    <= r1Col;
         r2Code   <= r1Code;
         r2Valid  <= r1Valid;
         r2Rgb    <= r1Rgb;
         r2Hcount <= r1Hcount;
         r2Vcount <= r1Vcount;
         r2Hsync  <= r1Hsync;
         r2Hblnk  <= r1Hblnk;
         r2Vsync  <= r1Vsync;
         r2Vblnk  <= r1Vblnk;
      end
   end

   // Stage 3 selects the pixel bit from the line. Bit 7 is the leftmost pixel.
   // Blanking wins over everything, and then glyph foreground wins over the
   // upstream colour.
   logic w_blank;
   logic w_bit;
   logic w_hit;

   assign w_blank = r2Hblnk || r2Vblnk;
   assign w_bit   = r2Line[3'd7 - r2Col];
   assign w_hit   = r2Valid && w_bit && !w_blank;

   // The output registers are the last stage of the pipeline.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rgb_out    <= '0;
         glyph_hit  <= 1'b0;
         hcount_out <= '0;
         vcount_out <= '0;
         hsync_out  <= 1'b0;
         hblnk_out  <= 1'b0;
         vsync_out  <= 1'b0;
         vblnk_out  <= 1'b0;
      end else begin
         if (w_blank) begin
            rgb_out <= BG_BLANK;
         end else if (w_hit) begin
            rgb_out <= fgColour(r2Code);
         end else begin
            rgb_out <= r2Rgb;
         end
         glyph_hit  <= w_hit;
         hcount_out <= r2Hcount;
         vcount_out <= r2Vcount;
         hsync_out  <= r2Hsync;
         hblnk_out  <= r2Hblnk;
         vsync_out  <= r2Vsync;
         vblnk_out  <= r2Vblnk;
      end
   end

endmodule

// File: tb/tb_num_glyph_pixel.sv
// Testbench for num_glyph_pixel (SCALE_LOG2 = 1, BG_BLANK = 12'h000).
// A linear sequence of directed pixels is driven, one per clock. Each pixel
// carries its hand-derived expected colour and hit flag. The output observed
// after each edge is compared with the pixel that was driven three cycles
// earlier.
module tb_num_glyph_pixel;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] hcount_in;
   logic        hsync_in;
   logic        hblnk_in;
   logic [10:0] vcount_in;
   logic        vsync_in;
   logic        vblnk_in;
   logic [11:0] rgb_in;
   logic [10:0] tile_x;
   logic [10:0] tile_y;
   logic [3:0]  glyph_code;
   logic        glyph_en;
   logic [10:0] hcount_out;
   logic        hsync_out;
   logic        hblnk_out;
   logic [10:0] vcount_out;
   logic        vsync_out;
   logic        vblnk_out;
   logic [11:0] rgb_out;
   logic        glyph_hit;

   int testsRun    = 0;
   int testsFailed = 0;
   int stepIdx     = 0;

   logic [25:0] histTiming [0:3];
   logic [11:0] histRgb    [0:3];
   logic        histHit    [0:3];
   string       histTag    [0:3];

   always #5 clk = ~clk;

   num_glyph_pixel #(
      .SCALE_LOG2 (1),
      .BG_BLANK   (12'h000)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .hcount_in  (hcount_in),
      .hsync_in   (hsync_in),
      .hblnk_in   (hblnk_in),
      .vcount_in  (vcount_in),
      .vsync_in   (vsync_in),
      .vblnk_in   (vblnk_in),
      .rgb_in     (rgb_in),
      .tile_x     (tile_x),
      .tile_y     (tile_y),
      .glyph_code (glyph_code),
      .glyph_en   (glyph_en),
      .hcount_out (hcount_out),
      .hsync_out  (hsync_out),
      .hblnk_out  (hblnk_out),
      .vcount_out (vcount_out),
      .vsync_out  (vsync_out),
      .vblnk_out  (vblnk_out),
      .rgb_out    (rgb_out),
      .glyph_hit  (glyph_hit)
   );

   // Digit-2 bitmap rows. This is the reference for the raster sweep.
   function automatic logic [7:0] dig2Row(input int r);
      case (r)
         2:       dig2Row = 8'h7C;
         3:       dig2Row = 8'hC6;
         4:       dig2Row = 8'h06;
         5:       dig2Row = 8'h0C;
         6:       dig2Row = 8'h18;
         7:       dig2Row = 8'h30;
         8:       dig2Row = 8'h60;
         9:       dig2Row = 8'hC0;
         10:      dig2Row = 8'hC6;
         11:      dig2Row = 8'hFE;
         default: dig2Row = 8'h00;
      endcase
   endfunction

   // Compares every output against the expected timing, colour and hit flag.
   task automatic checkOutput(input logic [25:0] expT, input logic [11:0] expRgb,
                              input logic expHit, input string tag);
      logic [25:0] obsT;
      obsT = {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out};
      testsRun++;
      assert (obsT === expT) else begin
         testsFailed++;
         $error("[TB] FAIL %s timing: observed %h expected %h", tag, obsT, expT);
      end
      testsRun++;
      assert (rgb_out === expRgb) else begin
         testsFailed++;
         $error("[TB] FAIL %s rgb_out: observed %h expected %h", tag, rgb_out, expRgb);
      end
      testsRun++;
      assert (glyph_hit === expHit) else begin
         testsFailed++;
         $error("[TB] FAIL %s glyph_hit: observed %b expected %b", tag, glyph_hit, expHit);
      end
   endtask

   // Drives one pixel, clocks it in and checks the output of the pixel driven
   // two steps earlier. Together with this edge that makes three cycles of
   // latency. The first two steps after a reset must still show all zeros.
   task automatic applyStimulus(input logic [10:0] hc, input logic [10:0] vc,
                                input logic hs, input logic hb, input logic vs, input logic vb,
                                input logic [11:0] rgb, input logic [10:0] tx, input logic [10:0] ty,
                                input logic [3:0] code, input logic en,
                                input logic [11:0] expRgb, input logic expHit, input string tag);
      hcount_in  = hc;
      vcount_in  = vc;
      hsync_in   = hs;
      hblnk_in   = hb;
      vsync_in   = vs;
      vblnk_in   = vb;
      rgb_in     = rgb;
      tile_x     = tx;
      tile_y     = ty;
      glyph_code = code;
      glyph_en   = en;
      histTiming[stepIdx % 4] = {hc, hs, hb, vc, vs, vb};
      histRgb[stepIdx % 4]    = expRgb;
      histHit[stepIdx % 4]    = expHit;
      histTag[stepIdx % 4]    = tag;
      @(posedge clk);
      #1;
      if (stepIdx >= 2) begin
         checkOutput(histTiming[(stepIdx - 2) % 4], histRgb[(stepIdx - 2) % 4],
                     histHit[(stepIdx - 2) % 4], histTag[(stepIdx - 2) % 4]);
      end else begin
         checkOutput(26'd0, 12'h000, 1'b0, "postResetFlush");
      end
      stepIdx++;
   endtask

   initial begin
      logic [7:0] rowBits;
      logic       expB;

      rst        = 1'b1;
      hcount_in  = '0;
      vcount_in  = '0;
      hsync_in   = 1'b0;
      hblnk_in   = 1'b0;
      vsync_in   = 1'b0;
      vblnk_in   = 1'b0;
      rgb_in     = '0;
      tile_x     = '0;
      tile_y     = '0;
      glyph_code = '0;
      glyph_en   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput(26'd0, 12'h000, 1'b0, "resetState");
      rst     = 1'b0;
      stepIdx = 0;

      // Digit 1 at (100,50). Pixel (106,54) maps to col 3, row 2, and line 0x18
      // has bit 4 set. Pixel (100,54) maps to col 0, which is clear.
      applyStimulus(11'd106, 11'd54, 0, 0, 0, 0, 12'hCCC, 11'd100, 11'd50, 4'd1, 1, 12'h00F, 1, "d1Hit");
      applyStimulus(11'd100, 11'd54, 0, 0, 0, 0, 12'hCCC, 11'd100, 11'd50, 4'd1, 1, 12'hCCC, 0, "d1Miss");
      applyStimulus(11'd107, 11'd55, 0, 0, 0, 0, 12'hCCC, 11'd100, 11'd50, 4'd1, 1, 12'h00F, 1, "d1HitOdd");
      applyStimulus(11'd106, 11'd52, 0, 0, 0, 0, 12'hCCC, 11'd100, 11'd50, 4'd1, 1, 12'hCCC, 0, "d1Row1");
      applyStimulus(11'd106, 11'd49, 0, 0, 0, 0, 12'hCCC, 11'd100, 11'd50, 4'd1, 1, 12'hCCC, 0, "aboveWin");
      applyStimulus(11'd106, 11'd82, 0, 0, 0, 0, 12'hCCC, 11'd100, 11'd50, 4'd1, 1, 12'hCCC, 0, "belowWin");

      // Blanking at a foreground pixel forces BG_BLANK and suppresses the hit.
      applyStimulus(11'd106, 11'd54, 0, 1, 0, 0, 12'hCCC, 11'd100, 11'd50, 4'd1, 1, 12'h000, 0, "hblnkFg");
      applyStimulus(11'd106, 11'd54, 0, 0, 1, 1, 12'hCCC, 11'd100, 11'd50, 4'd1, 1, 12'h000, 0, "vblnkFg");

      // Digit 2 over the whole 16x32 window, with every bitmap bit doubled.
      for (int y = 0; y < 32; y++) begin
         for (int x = 0; x < 16; x++) begin
            rowBits = dig2Row(y / 2);
            expB    = rowBits[7 - (x / 2)];
            applyStimulus(11'(100 + x), 11'(50 + y), 0, 0, 0, 0, 12'h5A5, 11'd100, 11'd50, 4'd2, 1,
                          expB ? 12'h080 : 12'h5A5, expB, "d2Raster");
         end
      end
      applyStimulus(11'd99,  11'd54, 0, 0, 0, 0, 12'h5A5, 11'd100, 11'd50, 4'd2, 1, 12'h5A5, 0, "leftEdge");
      applyStimulus(11'd116, 11'd54, 0, 0, 0, 0, 12'h5A5, 11'd100, 11'd50, 4'd2, 1, 12'h5A5, 0, "rightEdge");

      // Code 0, code 12 and glyph_en=0 must all pass the pixel through.
      for (int y = 0; y < 32; y++) begin
         for (int x = 0; x < 16; x++) begin
            applyStimulus(11'(100 + x), 11'(50 + y), 0, 0, 0, 0, 12'(x * 37 + y), 11'd100, 11'd50, 4'd0, 1,
                          12'(x * 37 + y), 0, "code0Pass");
            applyStimulus(11'(100 + x), 11'(50 + y), 0, 0, 0, 0, 12'(x * 37 + y), 11'd100, 11'd50, 4'd12, 1,
                          12'(x * 37 + y), 0, "code12Pass");
            applyStimulus(11'(100 + x), 11'(50 + y), 0, 0, 0, 0, 12'(x * 37 + y), 11'd100, 11'd50, 4'd2, 0,
                          12'(x * 37 + y), 0, "enOffPass");
         end
      end

      // Mine at tile_x=2040. Row 2 is 0x10, so only col 3 lights, which is
      // hcount 2046 and 2047. Counters 0..15 must not be taken as wrapped hits.
      for (int h = 2040; h < 2048; h++) begin
         applyStimulus(11'(h), 11'd54, 0, 0, 0, 0, 12'hCCC, 11'd2040, 11'd50, 4'd9, 1,
                       (h >= 2046) ? 12'h000 : 12'hCCC, (h >= 2046), "mineEdge");
      end
      for (int h = 0; h < 16; h++) begin
         applyStimulus(11'(h), 11'd54, 0, 0, 0, 0, 12'hCCC, 11'd2040, 11'd50, 4'd9, 1,
                       12'hCCC, 0, "mineNoWrap");
      end

      // One line with varying sync and blank. A one-cycle reset mid-line must
      // clear every output at once, and the pixels in flight are then lost.
      for (int h = 0; h < 40; h++) begin
         if (h == 20) begin
            rst = 1'b1;
            #1;
            checkOutput(26'd0, 12'h000, 1'b0, "midReset");
            @(posedge clk);
            #1;
            rst     = 1'b0;
            stepIdx = 0;
         end
         applyStimulus(11'(h), 11'd200, (h >= 10 && h < 16), (h >= 30), 0, 0, {1'b0, 11'(h)},
                       11'd100, 11'd50, 4'd0, 0, (h >= 30) ? 12'h000 : {1'b0, 11'(h)}, 0, "lineTiming");
      end

      // Two idle pixels push the last real pixel out of the pipeline.
      applyStimulus(11'd0, 11'd0, 0, 0, 0, 0, 12'h000, 11'd0, 11'd0, 4'd0, 0, 12'h000, 0, "drain");
      applyStimulus(11'd0, 11'd0, 0, 0, 0, 0, 12'h000, 11'd0, 11'd0, 4'd0, 0, 12'h000, 0, "drain");

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
